// File: rtl/font_line_prefetch.sv
// font_line_prefetch
//
// Line-ahead font prefetcher for the VGA text overlay. During horizontal
// blanking it walks the character field table, reads the font row of every
// field that covers the upcoming line from the shared font ROM, and stores
// it in the fetch half of a double-buffered line buffer. During the active
// line, pixels are served from the display half, so the pixel path never
// touches the ROM.
//
// Parameters:
//   NUM_FIELDS  number of character fields (1..8)
//   ROM_LAT     font ROM read latency, rom_rd -> rom_data valid (1..3)
//
// Ports:
//   clk, reset      pixel clock, synchronous active-high reset
//   h_blank_start   pulse: sample next_line and field table, start a fetch
//   line_start      pulse: swap fetch/display banks
//   next_line       y of the line to fetch
//   pixelx          current x in the active line
//   field_char/x/y/color  packed per-field table (field i at slice i)
//   rom_addr, rom_rd, rom_data  font ROM port ({char, row}, strobe, row bits)
//   pixel_on, color_addr        registered pixel result (one cycle behind pixelx)
//   overrun         sticky: a fetch was cut short by line_start or h_blank_start
//
// Optional feature macro FIELD_BLINK_EN adds frame_start / blink_mask and a
// frame counter; masked fields are hidden during the upper half of each
// 64-frame period.
module font_line_prefetch #(
  parameter int NUM_FIELDS = 6,
  parameter int ROM_LAT    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    h_blank_start,
  input  logic                    line_start,
`ifdef FIELD_BLINK_EN
  input  logic                    frame_start,
  input  logic [NUM_FIELDS-1:0]   blink_mask,
`endif
  input  logic [9:0]              next_line,
  input  logic [9:0]              pixelx,
  input  logic [7*NUM_FIELDS-1:0] field_char,
  input  logic [10*NUM_FIELDS-1:0] field_x,
  input  logic [10*NUM_FIELDS-1:0] field_y,
  input  logic [4*NUM_FIELDS-1:0] field_color,
  output logic [10:0]             rom_addr,
  output logic                    rom_rd,
  input  logic [7:0]              rom_data,
  output logic                    pixel_on,
  output logic [3:0]              color_addr,
  output logic                    overrun
);

  localparam int IW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, READ, WAIT, STORE} state_t;

  state_t state, state_n;

  logic [IW-1:0] idx;
  logic [1:0]    wcnt;

  // Field table snapshot taken at h_blank_start
  logic [9:0] line_q;
  logic [6:0] char_q [NUM_FIELDS];
  logic [9:0] x_q    [NUM_FIELDS];
  logic [9:0] y_q    [NUM_FIELDS];
  logic [3:0] col_q  [NUM_FIELDS];

  // Double-buffered line buffer; fb selects the bank being fetched into
  logic                  fb;
  logic                  db;
  logic [NUM_FIELDS-1:0] bval [2];
  logic [7:0]            brow [2][NUM_FIELDS];
  logic [9:0]            bx   [2][NUM_FIELDS];
  logic [3:0]            bcol [2][NUM_FIELDS];

  logic [9:0] cur_y;
  logic [9:0] row_diff;
  logic       field_active;
  logic       last_field;
  logic       store_commit;

  logic [NUM_FIELDS-1:0] blink_off;
  logic                  pix_on_n;
  logic [3:0]            pix_col_n;
  logic [9:0]            dx;

  assign db = ~fb;

  // ---------------------------------------------------------------- snapshot
  always_ff @(posedge clk) begin
    if (h_blank_start) begin
      line_q <= next_line;
      for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
        char_q[i] <= field_char[7*i +: 7];
        x_q[i]    <= field_x[10*i +: 10];
        y_q[i]    <= field_y[10*i +: 10];
        col_q[i]  <= field_color[4*i +: 4];
      end
    end
  end

  // The >= test guards the subtraction, so a field near y=1023 never
  // wraps around to match small line numbers.
  always_comb begin
    cur_y        = y_q[idx];
    row_diff     = line_q - cur_y;
    field_active = (line_q >= cur_y) && (row_diff[9:4] == '0);
    last_field   = (idx == IW'(NUM_FIELDS - 1));
  end

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = IDLE;
      CHECK: begin
        if (field_active)    state_n = READ;
        else if (last_field) state_n = IDLE;
      end
      READ:  state_n = (ROM_LAT == 1) ? STORE : WAIT;
      WAIT:  if (wcnt == 2'(ROM_LAT - 2)) state_n = STORE;
      STORE: state_n = last_field ? IDLE : CHECK;
      default: state_n = IDLE;
    endcase
    if (line_start)    state_n = IDLE;
    if (h_blank_start) state_n = CHECK;
  end

  // An abort by h_blank_start discards the STORE of the same cycle;
  // line_start does not, the row lands before the banks swap.
  assign store_commit = (state == STORE) && !h_blank_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      wcnt <= '0;
    end else begin
      if (h_blank_start)
        idx <= '0;
      else if ((state == CHECK && !field_active) || state == STORE)
        idx <= idx + IW'(1);

      if (state != WAIT) wcnt <= '0;
      else               wcnt <= wcnt + 2'd1;
    end
  end

  // rom_rd is registered so it is high exactly during READ; rom_addr holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_rd   <= 1'b0;
      rom_addr <= '0;
    end else begin
      rom_rd <= (state_n == READ);
      if (state_n == READ)
        rom_addr <= {char_q[idx], row_diff[3:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      overrun <= 1'b0;
    else if ((line_start || h_blank_start) && state != IDLE)
      overrun <= 1'b1;
  end

  // ----------------------------------------------------------- line buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      fb      <= 1'b0;
      bval[0] <= '0;
      bval[1] <= '0;
    end else begin
      if (store_commit)
        bval[fb][idx] <= 1'b1;
      if (line_start) begin
        fb       <= ~fb;
        bval[db] <= '0;
      end else if (h_blank_start) begin
        bval[fb] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store_commit) begin
      brow[fb][idx] <= rom_data;
      bx[fb][idx]   <= x_q[idx];
      bcol[fb][idx] <= col_q[idx];
    end
  end

  // ----------------------------------------------------------------- blink
`ifdef FIELD_BLINK_EN
  logic [5:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (reset)            frame_cnt <= '0;
    else if (frame_start) frame_cnt <= frame_cnt + 6'd1;
  end

  assign blink_off = frame_cnt[5] ? blink_mask : '0;
`else
  assign blink_off = '0;
`endif

  // --------------------------------------------------------- pixel service
  // Ascending scan; the first lit field found keeps priority.
  always_comb begin
    pix_on_n  = 1'b0;
    pix_col_n = '0;
    dx        = '0;
    for (int unsigned k = 0; k < NUM_FIELDS; k++) begin
      dx = pixelx - bx[db][k];
      if (!pix_on_n && bval[db][k] && !blink_off[k] && (dx < 10'd8) &&
          brow[db][k][3'd7 - dx[2:0]]) begin
        pix_on_n  = 1'b1;
        pix_col_n = bcol[db][k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_on   <= 1'b0;
      color_addr <= '0;
    end else begin
      pixel_on   <= pix_on_n;
      color_addr <= pix_col_n;
    end
  end

endmodule

// File: doc/font_line_prefetch.md
# font_line_prefetch

Line-ahead scheduler for the VGA text overlay: during horizontal blanking it walks a table of NUM_FIELDS character fields (clock digits, labels), fetches each active field's font row from the single shared 8x16 font ROM, and stores it in a double-buffered line buffer. During the active line it serves pixels from the buffer, so the ROM is never accessed in the pixel path. It sits between the time/digit registers and the RGB colour mux.

## Interface
- NUM_FIELDS, 6: number of character fields (1..8).
- ROM_LAT, 1: font ROM read latency in cycles, from `rom_rd` to valid `rom_data` (1..3).

- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- h_blank_start  in  1  one-cycle pulse at the start of horizontal blanking; starts a fetch.
- line_start  in  1  one-cycle pulse at the first active pixel of a line; swaps banks.
- next_line  in  10  y of the line to be fetched; sampled on `h_blank_start`.
- pixelx  in  10  current x during the active line.
- field_char  in  7*NUM_FIELDS  character code per field; field i uses bits [7i+6:7i].
- field_x  in  10*NUM_FIELDS  left x per field.
- field_y  in  10*NUM_FIELDS  top y per field; the field covers y .. y+15.
- field_color  in  4*NUM_FIELDS  colour index per field.
- rom_addr  out  11  {char[6:0], row[3:0]}.
- rom_rd  out  1  one-cycle read strobe.
- rom_data  in  8  font row; bit 7 is the leftmost pixel.
- pixel_on  out  1  a foreground pixel is present.
- color_addr  out  4  colour of the drawn pixel; 0 when `pixel_on`=0.
- overrun  out  1  sticky flag; set when a fetch did not finish before `line_start`; cleared only by reset.

## Operation
- FSM states: IDLE, CHECK, READ, WAIT, STORE.
- IDLE -> CHECK on `h_blank_start`:
  - latch `next_line` and all field inputs;
  - set i=0;
  - clear every valid bit in the fetch bank.
- CHECK, field i:
  - Active when next_line >= y_i and next_line - y_i < 16, using 10-bit unsigned compare with no wrap; y_i > 1008 never matches past 1023.
  - Inactive: i++ and stay in CHECK, 1 cycle, no ROM access.
  - Active: go to READ.
- READ:
  - drive `rom_addr`={char_i, (next_line - y_i)[3:0]} and `rom_rd`=1 for one cycle;
  - go to WAIT.
- WAIT: hold for ROM_LAT-1 cycles, then go to STORE.
- STORE:
  - capture `rom_data` into fetch-bank row i, together with x_i and colour_i;
  - set valid_i;
  - i++.
- After the last field, CHECK or STORE returns to IDLE.
- Bank swap on `line_start`: the fetch bank becomes the display bank, and the old display bank becomes the fetch bank with all valid bits cleared.
- `line_start` during a fetch:
  - swap anyway; fields not yet stored stay invalid (not drawn);
  - set `overrun`;
  - the FSM returns to IDLE;
  - a STORE in the same cycle as `line_start` is committed before the swap.
- `h_blank_start` while not IDLE:
  - abort, set `overrun`;
  - restart at CHECK with i=0 using the new sample.
- Pixel service, field i in the display bank:
  - hit when valid_i and 0 <= pixelx - x_i <= 7;
  - bit = row_i[7 - (pixelx - x_i)];
  - on overlap the lowest index with bit=1 wins.
- `rom_addr` holds its last value when `rom_rd`=0.

## Timing
- Fetch cost: 1 cycle per inactive field, ROM_LAT+2 cycles per active field. With NUM_FIELDS=6 and ROM_LAT=1, worst case is 18 cycles, which fits in a 160-cycle blank.
- `pixel_on` and `color_addr` are registered: they reflect the `pixelx` presented one cycle earlier.
- Reset values:
  - state IDLE;
  - `rom_rd`=0, `rom_addr`=0;
  - `pixel_on`=0, `color_addr`=0, `overrun`=0;
  - both banks invalid.
- Reset mid-fetch takes effect the next cycle; no pending STORE commits.

## Configuration
- FIELD_BLINK_EN defined:
  - adds inputs `frame_start` (1-cycle pulse per frame) and `blink_mask` (NUM_FIELDS);
  - a 6-bit frame counter increments on `frame_start` and resets to 0;
  - when counter[5]=1, fields with their mask bit set are suppressed at pixel service (fetch is unaffected).
- FIELD_BLINK_EN undefined: no such ports and no counter; fields are always drawn.

## Test plan
- After reset, with no pulses: `pixel_on`=0 and `color_addr`=0 for all pixelx; `rom_rd` never asserts.
- Field0: char=7'h31, x=2, y=3, color=2, next_line=5, ROM_LAT=1:
  - one read with rom_addr=11'h312;
  - with rom_data=8'b1000_0001 and then `line_start`, `pixel_on`=1 at pixelx=2 and 9, 0 at pixelx=3 and 10;
  - color_addr=2.
- All 6 fields active, ROM_LAT=3:
  - fetch takes 30 cycles;
  - `line_start` at cycle 12 -> only fields 0-1 are drawn, `overrun`=1 and it stays 1 afterwards.
- Fields 0 and 1 both at x=100 with the same line:
  - field0 row 8'h0F, field1 row 8'hF0;
  - pixelx=100..103 -> field1 colour, 104..107 -> field0 colour.
- next_line=19 with field y=3 -> not active, no `rom_rd`; next_line=18 -> row=4'hF.
- FIELD_BLINK_EN defined, mask=1: field0 is drawn for frames 0-31 and suppressed for frames 32-63.
